// File: rtl/axi4_burst_split46_pkg.sv
// Shared definitions for the 46-bit AXI4 read-address burst splitter.
// Holds payload field offsets/widths, burst encodings, the 4KB page size and the
// splitter FSM state type. Imported by axi4_burst_split46 and axi4_burst_split46_calc.
package axi4_burst_split46_pkg;

    // Payload layout: {burst[45:44], len[43:36], addr[35:4], id[3:0]}
    localparam int unsigned IdLsb    = 0;
    localparam int unsigned IdW      = 4;
    localparam int unsigned AddrLsb  = 4;
    localparam int unsigned AddrW    = 32;
    localparam int unsigned LenLsb   = 36;
    localparam int unsigned LenW     = 8;
    localparam int unsigned BurstLsb = 44;
    localparam int unsigned BurstW   = 2;
    localparam int unsigned PayloadW = 46;

    localparam int unsigned PageBytes = 4096;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } split_state_e;

endpackage

// File: rtl/axi4_burst_split46_calc.sv
// Combinational sub-burst calculator.
// Given the current address, remaining beat count and burst type, produces the
// AXI len of the piece to issue, the address and remaining count that follow it,
// and whether it is the final piece. Non-INCR bursts are emitted whole.
// Ports:
//   addr_i      current sub-burst start address
//   rem_i       remaining beats (1..256)
//   burst_i     AXI burst type
//   len_o       AXI len (beats-1) of this piece
//   addr_next_o start address of the following piece (mod 2^32)
//   rem_next_o  beats remaining after this piece
//   last_o      this piece completes the request
module axi4_burst_split46_calc
    import axi4_burst_split46_pkg::*;
#(
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic [31:0] addr_i,
    input  logic [8:0]  rem_i,
    input  logic [1:0]  burst_i,
    output logic [7:0]  len_o,
    output logic [31:0] addr_next_o,
    output logic [8:0]  rem_next_o,
    output logic        last_o
);

    localparam int unsigned Shift     = $clog2(BEAT_BYTES);
    localparam logic [12:0] AlignMask = ~13'(BEAT_BYTES - 1);

    logic [12:0] page_off;
    logic [12:0] pg;
    logic [8:0]  lim;
    logic [8:0]  beats;
    logic [8:0]  len_full;

    // Beats left in the page, counted from the beat-aligned start address.
    assign page_off = {1'b0, addr_i[11:0]} & AlignMask;
    assign pg       = (13'(PageBytes) - page_off) >> Shift;

    always_comb begin
        lim = 9'(MAX_BEATS);
        if (pg < {4'b0, lim}) begin
            lim = pg[8:0];
        end
        beats = rem_i;
        if (burst_i == BurstIncr && lim < rem_i) begin
            beats = lim;
        end
    end

    assign len_full    = beats - 9'd1;
    assign len_o       = len_full[7:0];
    assign addr_next_o = addr_i + (32'(beats) << Shift);
    assign rem_next_o  = rem_i - beats;
    assign last_o      = (burst_i != BurstIncr) || (rem_next_o == 9'd0);

endmodule

// File: rtl/axi4_burst_split46.sv
// AXI4 read-address burst splitter fed from a 46-bit CDC FIFO.
// Pops one request at a time and issues INCR bursts as sub-bursts that neither cross
// a 4KB page nor exceed MAX_BEATS; FIXED/WRAP/reserved pass through unchanged.
// Optional feature macro: AXI4_BURST_SPLIT_STATS_EN enables the split counter.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   fifo_data_i     FIFO head entry {burst, len, addr, id}
//   fifo_empty_i    FIFO empty
//   fifo_pop_o      pop FIFO head (combinational)
//   out_valid_o     sub-burst valid
//   out_data_o      sub-burst payload (same layout as input)
//   out_last_o      final piece of the current request
//   out_accept_i    downstream accepts this cycle
//   stat_split_o    extra sub-bursts generated (0 when stats disabled)
module axi4_burst_split46
    import axi4_burst_split46_pkg::*;
#(
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [PayloadW-1:0] fifo_data_i,
    input  logic                fifo_empty_i,
    output logic                fifo_pop_o,
    output logic                out_valid_o,
    output logic [PayloadW-1:0] out_data_o,
    output logic                out_last_o,
    input  logic                out_accept_i,
    output logic [15:0]         stat_split_o
);

    split_state_e state_q;
    logic [31:0]  addr_q;   // start of the next piece (after the one presented)
    logic [8:0]   rem_q;    // beats left after the piece presented
    logic [1:0]   burst_q;
    logic [3:0]   id_q;

    logic         adv;
    logic [31:0]  c_addr;
    logic [8:0]   c_rem;
    logic [1:0]   c_burst;
    logic [7:0]   c_len;
    logic [31:0]  c_addr_next;
    logic [8:0]   c_rem_next;
    logic         c_last;

    assign adv = (state_q == StActive) && out_accept_i;

    // Pop when idle, or on the accept of the final piece so the next entry follows
    // with no bubble.
    assign fifo_pop_o = rst_ni && !fifo_empty_i &&
                        ((state_q == StIdle) || (adv && out_last_o));

    // The calculator works on the FIFO head when loading, else on the stored remainder.
    assign c_addr  = fifo_pop_o ? fifo_data_i[AddrLsb +: AddrW] : addr_q;
    assign c_rem   = fifo_pop_o ? ({1'b0, fifo_data_i[LenLsb +: LenW]} + 9'd1) : rem_q;
    assign c_burst = fifo_pop_o ? fifo_data_i[BurstLsb +: BurstW] : burst_q;

    axi4_burst_split46_calc #(
        .MAX_BEATS  (MAX_BEATS),
        .BEAT_BYTES (BEAT_BYTES)
    ) u_calc (
        .addr_i      (c_addr),
        .rem_i       (c_rem),
        .burst_i     (c_burst),
        .len_o       (c_len),
        .addr_next_o (c_addr_next),
        .rem_next_o  (c_rem_next),
        .last_o      (c_last)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            addr_q      <= '0;
            rem_q       <= '0;
            burst_q     <= '0;
            id_q        <= '0;
        end else if (fifo_pop_o) begin
            state_q     <= StActive;
            out_valid_o <= 1'b1;
            out_data_o  <= {c_burst, c_len, c_addr, fifo_data_i[IdLsb +: IdW]};
            out_last_o  <= c_last;
            addr_q      <= c_addr_next;
            rem_q       <= c_rem_next;
            burst_q     <= c_burst;
            id_q        <= fifo_data_i[IdLsb +: IdW];
        end else if (adv) begin
            if (out_last_o) begin
                state_q     <= StIdle;
                out_valid_o <= 1'b0;
            end else begin
                out_data_o <= {burst_q, c_len, addr_q, id_q};
                out_last_o <= c_last;
                addr_q     <= c_addr_next;
                rem_q      <= c_rem_next;
            end
        end
    end

`ifdef AXI4_BURST_SPLIT_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else if (out_valid_o && out_accept_i && !out_last_o && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_split_o = stat_q;
`else
    assign stat_split_o = '0;
`endif

endmodule

// File: tb/tb_axi4_burst_split46.sv
module tb_axi4_burst_split46;

    localparam int unsigned MB = 16;
    localparam int unsigned BB = 4;

    typedef struct {
        logic [45:0] data;
        logic        last;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [45:0] fifo_data_i = '0;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_pop_o;
    logic        out_valid_o;
    logic [45:0] out_data_o;
    logic        out_last_o;
    logic        out_accept_i = 1'b1;
    logic [15:0] stat_split_o;

    int total = 0;
    int bad = 0;

    logic [45:0] fq[$];
    exp_t        exp_q[$];
    int          exp_split = 0;
    int          pops = 0;
    bit          acc_rand = 0;
    bit          lat_pend = 0;
    bit          hold_pend = 0;
    bit          bubble_pend = 0;
    logic [45:0] hold_data;
    logic        hold_last;

    always #5 clk_i = ~clk_i;

    axi4_burst_split46 #(
        .MAX_BEATS  (MB),
        .BEAT_BYTES (BB)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_pop_o   (fifo_pop_o),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_accept_i (out_accept_i),
        .stat_split_o (stat_split_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_drive();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() == 0) ? 46'h0 : fq[0];
    endtask

    // Reference model: split a request into its expected output pieces.
    task automatic push_req(input logic [1:0] burst, input int unsigned len,
                            input logic [31:0] addr, input logic [3:0] id);
        logic [45:0] ent;
        int unsigned r, pg, b;
        logic [31:0] a;
        logic [7:0]  l8;
        ent = {burst, 8'(len), addr, id};
        fq.push_back(ent);
        if (burst != 2'b01) begin
            exp_q.push_back('{ent, 1'b1});
        end else begin
            r = len + 1;
            a = addr;
            while (r > 0) begin
                pg = (4096 - ((a % 4096) & ~(BB - 1))) / BB;
                b = r;
                if (b > MB) b = MB;
                if (b > pg) b = pg;
                r = r - b;
                l8 = 8'(b - 1);
                exp_q.push_back('{{burst, l8, a, id}, (r == 0)});
                a = a + 32'(b * BB);
            end
        end
        fifo_drive();
    endtask

    // One clock: observe at the negedge, apply FIFO/accept updates 1ns after posedge.
    task automatic cycle();
        bit   pop_seen;
        logic exp_pop;
        exp_t e;
        @(negedge clk_i);
        if (lat_pend) chk("latency", 64'(out_valid_o), 64'd1);
        if (bubble_pend) chk("no_bubble", 64'(out_valid_o), 64'd1);
        if (hold_pend) begin
            chk("hold_data", 64'(out_data_o), 64'(hold_data));
            chk("hold_last", 64'(out_last_o), 64'(hold_last));
        end
        hold_pend = 0;
        bubble_pend = 0;
        exp_pop = (fq.size() != 0) &&
                  (!out_valid_o || (out_accept_i && exp_q.size() != 0 && exp_q[0].last));
        chk("pop", 64'(fifo_pop_o), 64'(exp_pop));
        if (out_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", 64'(out_valid_o), 64'd0);
            end else if (out_accept_i) begin
                e = exp_q.pop_front();
                chk("data", 64'(out_data_o), 64'(e.data));
                chk("last", 64'(out_last_o), 64'(e.last));
                if (!e.last) exp_split++;
                if (e.last && fq.size() != 0) bubble_pend = 1;
            end else begin
                hold_pend = 1;
                hold_data = out_data_o;
                hold_last = out_last_o;
            end
        end
        pop_seen = fifo_pop_o;
        lat_pend = pop_seen;
        if (pop_seen) pops++;
        @(posedge clk_i);
        #1;
        if (pop_seen && fq.size() != 0) void'(fq.pop_front());
        fifo_drive();
        if (acc_rand) out_accept_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic check_stat();
`ifdef AXI4_BURST_SPLIT_STATS_EN
        chk("stat", 64'(stat_split_o), 64'(exp_split > 65535 ? 65535 : exp_split));
`else
        chk("stat", 64'(stat_split_o), 64'd0);
`endif
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drained", 64'(exp_q.size() == 0 && fq.size() == 0), 64'd1);
        cycle();
        check_stat();
    endtask

    initial begin
        logic [1:0]  rb;
        logic [31:0] ra;
        // Reset state with an entry already waiting: no pop while in reset.
        push_req(2'b01, 7, 32'h0000_1000, 4'h1);
        #12;
        chk("rst_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data", 64'(out_data_o), 64'd0);
        chk("rst_last", 64'(out_last_o), 64'd0);
        chk("rst_stat", 64'(stat_split_o), 64'd0);
        chk("rst_pop", 64'(fifo_pop_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Case 1: aligned, no split, exactly one pop.
        pops = 0;
        run(50);
        chk("case1_pops", 64'(pops), 64'd1);

        // Case 2: page crossing.
        push_req(2'b01, 7, 32'h0000_0FF0, 4'h2);
        run(50);

        // Case 3: length split into four.
        push_req(2'b01, 63, 32'h0000_2000, 4'h3);
        run(50);

        // Case 4: FIXED across a page, WRAP.
        push_req(2'b00, 31, 32'h0000_0FF0, 4'h4);
        push_req(2'b10, 3, 32'h0000_0040, 4'h5);
        run(50);

        // Case 5: back-pressure for 5 cycles with two entries queued.
        push_req(2'b01, 63, 32'h0000_2000, 4'h6);
        push_req(2'b01, 7, 32'h0000_3000, 4'h7);
        out_accept_i = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_fifo_kept", 64'(fq.size()), 64'd1);
        out_accept_i = 1'b1;
        run(50);

        // Case 6: reset while the second piece of a split is presented.
        push_req(2'b01, 63, 32'h0000_2000, 4'h8);
        while (exp_q.size() > 3) cycle();
        chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
        chk("mid_rst_stat", 64'(stat_split_o), 64'd0);
        exp_q.delete();
        exp_split = 0;
        lat_pend = 0;
        hold_pend = 0;
        bubble_pend = 0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        push_req(2'b01, 15, 32'h0000_0FE0, 4'h9);
        run(50);

        // Wrap of the 32-bit address space.
        push_req(2'b01, 15, 32'hFFFF_FFF0, 4'hA);
        run(50);

        // Randomized traffic with random back-pressure.
        acc_rand = 1;
        for (int batch = 0; batch < 8; batch++) begin
            for (int k = 0; k < 5; k++) begin
                rb = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
                ra = $urandom;
                if ($urandom_range(0, 1) != 0) ra[11:0] = 12'(4096 - $urandom_range(1, 300));
                push_req(rb, $urandom_range(0, 255), ra, 4'($urandom_range(0, 15)));
            end
            run(2000);
        end
        acc_rand = 0;
        out_accept_i = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
